// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache refill read arbiter.
// Holds the arbiter FSM encoding, requester identity, fixed AXI
// attributes and the default geometry of a cache-line refill.
package cache_axi_pkg;

  // Arbiter phases: waiting for a requester, presenting AR, collecting R.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  // Which refill port owns the outstanding read.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } side_e;

  // Every beat is one 32-bit word on an incrementing burst.
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Default refill geometry and AXI ids for the two requesters.
  localparam int LINE_BEATS = 8;
  localparam int ID_I       = 0;
  localparam int ID_D       = 1;

  // AXI encodes burst length as beats minus one.
  function automatic logic [7:0] burst_len(input int beats);
    return 8'(beats - 1);
  endfunction

endpackage

// File: rtl/rd_rr_pick.sv
// Two-requester round-robin chooser for the refill read arbiter.
// When enabled, a lone request is granted outright; on a tie the side
// that did not win last time is granted. The last winner is remembered
// in last_grant_q, which resets to D so that I wins the first tie.
module rd_rr_pick
  import cache_axi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic grant_i,
  output logic grant_d
);

  side_e last_grant_q;
  side_e last_grant_d;

  // Grant decision and last-winner update, purely from current inputs.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    last_grant_d = last_grant_q;

    if (en) begin
      grant_i = req_i && (!req_d || (last_grant_q == OWN_D));
      grant_d = req_d && (!req_i || (last_grant_q == OWN_I));
    end

    if (grant_i) begin
      last_grant_d = OWN_I;
    end else if (grant_d) begin
      last_grant_d = OWN_D;
    end
  end

  // Last-winner register; D after reset so the first tie goes to I.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values regardless of block order.
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Refill read arbiter shared by the instruction and data caches.
// Multiplexes the I-cache line refills and the D-cache line or
// single-word reads onto one AXI AR/R channel pair, with at most one
// read outstanding. Return beats are passed through combinationally to
// the port that owns the read, and a sticky proto_err flag records any
// R-channel behaviour that does not match the issued request.
module cache_rd_arbiter #(
  parameter int LINE_BEATS = cache_axi_pkg::LINE_BEATS,
  parameter int ID_I       = cache_axi_pkg::ID_I,
  parameter int ID_D       = cache_axi_pkg::ID_D
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction-cache refill port
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  output logic        i_rd_rdy,
  output logic [31:0] i_ret_data,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  // Data-cache refill / uncached-load port
  input  logic        d_rd_req,
  input  logic        d_rd_type,
  input  logic [31:0] d_rd_addr,
  output logic        d_rd_rdy,
  output logic [31:0] d_ret_data,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  // AXI read-address channel
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  // AXI read-data channel
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic [3:0]  rid,
  // Sticky protocol error
  output logic        proto_err
);

  import cache_axi_pkg::state_e;
  import cache_axi_pkg::side_e;
  import cache_axi_pkg::IDLE;
  import cache_axi_pkg::AR;
  import cache_axi_pkg::R;
  import cache_axi_pkg::OWN_I;
  import cache_axi_pkg::OWN_D;
  import cache_axi_pkg::AXI_SIZE_WORD;
  import cache_axi_pkg::AXI_BURST_INCR;
  import cache_axi_pkg::burst_len;

  localparam logic [7:0] LINE_LEN = burst_len(LINE_BEATS);
  localparam logic [3:0] ARID_I   = 4'(ID_I);
  localparam logic [3:0] ARID_D   = 4'(ID_D);

  state_e      state_q,     state_d;
  side_e       owner_q,     owner_d;
  logic [31:0] araddr_q,    araddr_d;
  logic [7:0]  arlen_q,     arlen_d;
  logic [3:0]  arid_q,      arid_d;
  logic [7:0]  beat_q,      beat_d;
  logic        proto_err_q, proto_err_d;

  logic pick_en;
  logic grant_i;
  logic grant_d;
  logic beat_fire;

  // Grants are only offered while idle; holding reset also suppresses
  // them so no rdy can be seen during reset.
  assign pick_en   = (state_q == IDLE) && !rst;
  assign beat_fire = (state_q == R) && rvalid;

  rd_rr_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .en      (pick_en),
    .req_i   (i_rd_req),
    .req_d   (d_rd_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Request acceptance is the grant itself, visible in the same cycle.
  assign i_rd_rdy = grant_i;
  assign d_rd_rdy = grant_d;

  // AR channel is driven straight from the latched request.
  assign arvalid = (state_q == AR);
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arid    = arid_q;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  assign rready    = (state_q == R);
  assign proto_err = proto_err_q;

  // Next-state logic: latch a granted request, wait for AR, count beats.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    beat_d   = beat_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          owner_d  = OWN_I;
          araddr_d = i_rd_addr;
          arlen_d  = LINE_LEN;
          arid_d   = ARID_I;
          state_d  = AR;
        end else if (grant_d) begin
          owner_d  = OWN_D;
          araddr_d = d_rd_addr;
          arlen_d  = d_rd_type ? LINE_LEN : 8'd0;
          arid_d   = ARID_D;
          state_d  = AR;
        end
      end

      AR: begin
        if (arready) begin
          beat_d  = 8'd0;
          state_d = R;
        end
      end

      R: begin
        if (rvalid) begin
          beat_d = beat_q + 8'd1;
          // The burst ends on rlast even if it arrives on the wrong beat;
          // the checker below flags the mismatch.
          if (rlast) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Protocol checker: once set, proto_err holds until reset.
  always_comb begin
    proto_err_d = proto_err_q;

    // Read data with no burst in flight.
    if (rvalid && (state_q != R)) begin
      proto_err_d = 1'b1;
    end

    if (beat_fire) begin
      // Beat tagged for a different requester than the one issued.
      if (rid != arid_q) begin
        proto_err_d = 1'b1;
      end
      // beat_q is the zero-based index of this beat, so rlast belongs
      // exactly on index arlen; early and missing rlast both trip here.
      if (rlast != (beat_q == arlen_q)) begin
        proto_err_d = 1'b1;
      end
    end
  end

  // Return-path steering: only the owner sees R data while in R.
  always_comb begin
    i_ret_data  = 32'd0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    d_ret_data  = 32'd0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;

    if (state_q == R) begin
      if (owner_q == OWN_I) begin
        i_ret_data  = rdata;
        i_ret_valid = rvalid;
        i_ret_last  = rvalid && rlast;
      end else begin
        d_ret_data  = rdata;
        d_ret_valid = rvalid;
        d_ret_last  = rvalid && rlast;
      end
    end
  end

  // State and request registers with immediate reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      araddr_q    <= 32'd0;
      arlen_q     <= 8'd0;
      arid_q      <= 4'd0;
      beat_q      <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arid_q      <= arid_d;
      beat_q      <= beat_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Self-checking bench for cache_rd_arbiter.
// The stimulus process plays both cache ports and a directed AXI slave;
// each issued request pushes its expected AR and R-beat responses into
// queues, and an independent monitor pops and compares them whenever
// the DUT presents an AR handshake or a return beat.
module tb_cache_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        i_rd_req;
  logic [31:0] i_rd_addr;
  logic        i_rd_rdy;
  logic [31:0] i_ret_data;
  logic        i_ret_valid;
  logic        i_ret_last;
  logic        d_rd_req;
  logic        d_rd_type;
  logic [31:0] d_rd_addr;
  logic        d_rd_rdy;
  logic [31:0] d_ret_data;
  logic        d_ret_valid;
  logic        d_ret_last;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;
  logic        proto_err;

  cache_rd_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_rd_req    (i_rd_req),
    .i_rd_addr   (i_rd_addr),
    .i_rd_rdy    (i_rd_rdy),
    .i_ret_data  (i_ret_data),
    .i_ret_valid (i_ret_valid),
    .i_ret_last  (i_ret_last),
    .d_rd_req    (d_rd_req),
    .d_rd_type   (d_rd_type),
    .d_rd_addr   (d_rd_addr),
    .d_rd_rdy    (d_rd_rdy),
    .d_ret_data  (d_ret_data),
    .d_ret_valid (d_ret_valid),
    .d_ret_last  (d_ret_last),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arid        (arid),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rlast       (rlast),
    .rid         (rid),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_exp_t;

  typedef struct {
    bit          side;   // 0 = I port, 1 = D port
    logic [31:0] data;
    bit          last;
  } ret_exp_t;

  ar_exp_t  ar_q[$];
  ret_exp_t ret_q[$];
  ar_exp_t  ea;
  ret_exp_t er;
  int       n_vec = 0;
  int       n_bad = 0;
  int       w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every AR handshake and return beat with the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL ar_unexpected: araddr 0x%08h with nothing expected", araddr);
        end else begin
          ea = ar_q.pop_front();
          check("ar_addr", araddr, ea.addr);
          check("ar_len", 32'(arlen), 32'(ea.len));
          check("ar_id", 32'(arid), 32'(ea.id));
          check("ar_size", 32'(arsize), 32'h2);
          check("ar_burst", 32'(arburst), 32'h1);
        end
      end
      if (i_ret_valid || d_ret_valid) begin
        if (ret_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL ret_unexpected: i_valid %0b d_valid %0b with nothing expected",
                   i_ret_valid, d_ret_valid);
        end else begin
          er = ret_q.pop_front();
          check("ret_i_valid", 32'(i_ret_valid), er.side ? 32'd0 : 32'd1);
          check("ret_d_valid", 32'(d_ret_valid), er.side ? 32'd1 : 32'd0);
          check("ret_data", er.side ? d_ret_data : i_ret_data, er.data);
          check("ret_last", 32'(er.side ? d_ret_last : i_ret_last), 32'(er.last));
        end
      end
    end
  end

  task automatic exp_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    ar_exp_t e;
    e.addr = addr;
    e.len  = len;
    e.id   = id;
    ar_q.push_back(e);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait (bounded) for the given side's rdy; optionally drop its request.
  task automatic wait_grant(input bit side_d, input bit drop, input string name,
                            output int waited);
    int  n   = 0;
    bit  got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (side_d ? d_rd_rdy : i_rd_rdy) got = 1'b1;
      else n++;
    end
    check({name, "_granted"}, 32'(got), 32'd1);
    if (got) check({name, "_other_rdy"}, 32'(side_d ? i_rd_rdy : d_rd_rdy), 32'd0);
    @(posedge clk);
    #1;
    if (drop) begin
      if (side_d) d_rd_req = 1'b0;
      else        i_rd_req = 1'b0;
    end
    waited = n;
  endtask

  // Hold arready low for 'delay' cycles, then accept the address.
  task automatic do_ar(input int delay, input string name);
    logic [31:0] a0 = araddr;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      check({name, "_arvalid_held"}, 32'(arvalid), 32'd1);
      check({name, "_araddr_held"}, araddr, a0);
      check({name, "_rready_early"}, 32'(rready), 32'd0);
      check({name, "_rdy_in_ar"}, 32'(i_rd_rdy | d_rd_rdy), 32'd0);
      @(posedge clk);
      #1;
    end
    arready = 1'b1;
    @(negedge clk);
    check({name, "_arvalid_hs"}, 32'(arvalid), 32'd1);
    @(posedge clk);
    #1 arready = 1'b0;
    check({name, "_arvalid_drop"}, 32'(arvalid), 32'd0);
    check({name, "_rready_on"}, 32'(rready), 32'd1);
  endtask

  // Drive n consecutive beats; rlast on index last_idx.
  task automatic beats(input bit side_d, input int n, input logic [31:0] base,
                       input logic [3:0] id, input int last_idx);
    ret_exp_t e;
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rdata  = base + 32'(k);
      rid    = id;
      rlast  = (k == last_idx);
      e.side = side_d;
      e.data = base + 32'(k);
      e.last = (k == last_idx);
      ret_q.push_back(e);
      @(negedge clk);
      check("no_grant_in_r", 32'(i_rd_rdy | d_rd_rdy), 32'd0);
      @(posedge clk);
      #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rid    = 4'd0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    i_rd_req  = 1'b1;   // must not be granted while reset is held
    i_rd_addr = 32'h1C00_0000;
    d_rd_req  = 1'b0;
    d_rd_type = 1'b0;
    d_rd_addr = 32'd0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = 32'd0;
    rlast     = 1'b0;
    rid       = 4'd0;

    // Reset state
    @(negedge clk);
    check("rst_i_rdy", 32'(i_rd_rdy), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_arlen", 32'(arlen), 32'd0);
    check("rst_arid", 32'(arid), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_ret_valid", 32'(i_ret_valid | d_ret_valid), 32'd0);
    i_rd_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: single I line refill, immediate arready, 8 beats A0..A7
    i_rd_addr = 32'h1C00_0020;
    i_rd_req  = 1'b1;
    exp_ar(32'h1C00_0020, 8'd7, 4'd0);
    wait_grant(1'b0, 1'b1, "t1", w);
    check("t1_grant_wait", 32'(w), 32'd0);
    do_ar(0, "t1");
    beats(1'b0, 8, 32'hA0, 4'd0, 7);
    @(negedge clk);
    check("t1_proto_err", 32'(proto_err), 32'd0);
    check("t1_idle_arvalid", 32'(arvalid), 32'd0);
    @(posedge clk);
    #1;

    // 2: tie after reset goes to I; D word read follows right after rlast
    pulse_reset();
    i_rd_addr = 32'h1C00_0040;
    d_rd_addr = 32'h8000_1004;
    d_rd_type = 1'b0;
    i_rd_req  = 1'b1;
    d_rd_req  = 1'b1;
    exp_ar(32'h1C00_0040, 8'd7, 4'd0);
    exp_ar(32'h8000_1004, 8'd0, 4'd1);
    wait_grant(1'b0, 1'b1, "t2_i", w);
    do_ar(0, "t2_i");
    beats(1'b0, 8, 32'hB0, 4'd0, 7);
    wait_grant(1'b1, 1'b1, "t2_d", w);
    check("t2_d_next_cycle", 32'(w), 32'd0);
    do_ar(0, "t2_d");
    beats(1'b1, 1, 32'hC0, 4'd1, 0);

    // 3: both held high, grants alternate I, D, I, D
    i_rd_addr = 32'h0000_0100;
    d_rd_addr = 32'h8000_2000;
    d_rd_type = 1'b1;
    i_rd_req  = 1'b1;
    d_rd_req  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) exp_ar(32'h0000_0100, 8'd7, 4'd0);
      else            exp_ar(32'h8000_2000, 8'd7, 4'd1);
      wait_grant(t % 2 == 1, t >= 2, "t3", w);
      check("t3_grant_wait", 32'(w), 32'd0);
      do_ar(0, "t3");
      beats(t % 2 == 1, 8, 32'h3000_0000 + 32'(t * 16), (t % 2 == 1) ? 4'd1 : 4'd0, 7);
    end

    // 4: arready delayed 5 cycles on a D word read
    d_rd_addr = 32'h8000_3008;
    d_rd_type = 1'b0;
    d_rd_req  = 1'b1;
    exp_ar(32'h8000_3008, 8'd0, 4'd1);
    wait_grant(1'b1, 1'b1, "t4", w);
    do_ar(5, "t4");
    beats(1'b1, 1, 32'hDEAD_BEEF, 4'd1, 0);
    @(negedge clk);
    check("t4_proto_err", 32'(proto_err), 32'd0);
    @(posedge clk);
    #1;

    // 5a: early rlast on beat 6 of a line
    i_rd_addr = 32'h1C00_0080;
    i_rd_req  = 1'b1;
    exp_ar(32'h1C00_0080, 8'd7, 4'd0);
    wait_grant(1'b0, 1'b1, "t5a", w);
    do_ar(0, "t5a");
    beats(1'b0, 6, 32'hE0, 4'd0, 5);
    @(negedge clk);
    check("t5a_proto_err", 32'(proto_err), 32'd1);
    check("t5a_idle_rready", 32'(rready), 32'd0);
    check("t5a_idle_arvalid", 32'(arvalid), 32'd0);
    repeat (3) @(negedge clk);
    check("t5a_proto_sticky", 32'(proto_err), 32'd1);
    @(posedge clk);
    #1;

    // 5b: wrong rid during an I transfer
    pulse_reset();
    check("t5b_proto_cleared", 32'(proto_err), 32'd0);
    i_rd_req = 1'b1;
    exp_ar(32'h1C00_0080, 8'd7, 4'd0);
    wait_grant(1'b0, 1'b1, "t5b", w);
    do_ar(0, "t5b");
    beats(1'b0, 8, 32'hF0, 4'd1, 7);
    @(negedge clk);
    check("t5b_proto_err", 32'(proto_err), 32'd1);
    @(posedge clk);
    #1;

    // 5c: rvalid while idle
    pulse_reset();
    rvalid = 1'b1;
    @(posedge clk);
    #1 rvalid = 1'b0;
    @(negedge clk);
    check("t5c_proto_err", 32'(proto_err), 32'd1);
    @(posedge clk);
    #1;

    // 6: reset during beat 3 of a burst (proto_err already set by rid)
    pulse_reset();
    i_rd_addr = 32'h1C00_00A0;
    i_rd_req  = 1'b1;
    exp_ar(32'h1C00_00A0, 8'd7, 4'd0);
    wait_grant(1'b0, 1'b1, "t6", w);
    do_ar(0, "t6");
    beats(1'b0, 2, 32'h60, 4'd1, 7);
    check("t6_proto_before", 32'(proto_err), 32'd1);
    rvalid = 1'b1;
    rdata  = 32'h62;
    rid    = 4'd0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_arvalid", 32'(arvalid), 32'd0);
    check("t6_rst_rready", 32'(rready), 32'd0);
    check("t6_rst_ret_valid", 32'(i_ret_valid), 32'd0);
    check("t6_rst_proto_err", 32'(proto_err), 32'd0);
    rvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    d_rd_addr = 32'h8000_4000;
    d_rd_type = 1'b0;
    d_rd_req  = 1'b1;
    exp_ar(32'h8000_4000, 8'd0, 4'd1);
    wait_grant(1'b1, 1'b1, "t6_after", w);
    check("t6_after_wait", 32'(w), 32'd0);
    do_ar(0, "t6_after");
    beats(1'b1, 1, 32'h44, 4'd1, 0);
    @(negedge clk);
    check("t6_after_proto", 32'(proto_err), 32'd0);

    // Every expected response must have been observed
    check("ar_queue_empty", 32'(ar_q.size()), 32'd0);
    check("ret_queue_empty", 32'(ret_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
